adder_tree_layer_hs: RTL

ADDER_TREE_LAYER_HS -- requirements
Module: adder_tree_layer_hs

---
 rtl/adder_tree_layer_hs.sv | 98 +++++++++
 1 files changed

// File: rtl/adder_tree_layer_hs.sv
// adder_tree_layer_hs: one pairwise add layer (odd words shifted) behind a 2-entry skid buffer
module adder_tree_layer_hs #(
  parameter int NUM_IN_WORDS      = 5,
  parameter int BITS_PER_IN_WORD  = 16,
  parameter int BITS_PER_OUT_WORD = 17,
  parameter int SIGN_EXT          = 1,
  parameter int SHIFT             = 1,
  parameter int SATURATE          = 0
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [NUM_IN_WORDS*BITS_PER_IN_WORD-1:0]      in_words,
  input  logic                                          in_valid,
  input  logic                                          in_last,
  output logic                                          in_ready,
  output logic [(NUM_IN_WORDS/2+NUM_IN_WORDS%2)*BITS_PER_OUT_WORD-1:0] out_words,
  output logic                                          out_valid,
  output logic                                          out_last,
  input  logic                                          out_ready,
  output logic                                          ovf
);
  localparam int NOW = NUM_IN_WORDS/2 + NUM_IN_WORDS%2;
  localparam int BI  = BITS_PER_IN_WORD;
  localparam int OW  = BITS_PER_OUT_WORD;
  localparam int FW  = BI + SHIFT + 1;
  localparam int P   = NOW*OW + 1;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  logic [NOW*OW-1:0] res;
  logic [NOW-1:0] ovw;
  genvar i;
  for (i = 0; i < NOW; i++) begin : g_word
    logic [BI-1:0] wa, wb;
    logic [FW-1:0] ea, eb, sum;
    logic [OW-1:0] sat;
    logic ov;
    assign wa = in_words[2*i*BI +: BI];
    if (2*i+1 < NUM_IN_WORDS) begin : g_pair
      assign wb = in_words[(2*i+1)*BI +: BI];
    end else begin : g_odd
      assign wb = '0;
    end
    assign ea = {{(FW-BI){SIGN_EXT != 0 && wa[BI-1]}}, wa};
    assign eb = {{(FW-BI){SIGN_EXT != 0 && wb[BI-1]}}, wb};
    assign sum = ea + (eb << SHIFT);
    if (OW >= FW) begin : g_fit
      assign ov = 1'b0;
    end else if (SIGN_EXT != 0) begin : g_s
      assign ov = !(&sum[FW-1:OW-1] || ~|sum[FW-1:OW-1]);
    end else begin : g_u
      assign ov = |sum[FW-1:OW];
    end
    assign sat = SIGN_EXT != 0 ? {sum[FW-1], {(OW-1){~sum[FW-1]}}} : {OW{1'b1}};
    assign res[i*OW +: OW] = (ov && SATURATE != 0) ? sat : sum[OW-1:0];
    assign ovw[i] = ov;
  end
  state_t state_q, state_d;
  logic [P-1:0] o_q, o_d, s_q, s_d, new_p;
  logic ovf_q, ovf_d, in_ready_q, acc, drn;
  assign new_p = {in_last, res};
  assign acc = in_valid && in_ready_q;
  assign drn = state_q != EMPTY && out_ready;
  assign ovf_d = ovf_q | (acc & |ovw);
  // occupancy transitions and steering of new/skid data into O and S
  always_comb begin
    state_d = state_q;
    o_d = o_q;
    s_d = s_q;
    unique case (state_q)
      EMPTY: if (acc) begin state_d = ONE; o_d = new_p; end
      ONE: if (acc && drn) o_d = new_p;
           else if (acc) begin state_d = TWO; s_d = new_p; end
           else if (drn) state_d = EMPTY;
      TWO: if (drn) begin state_d = ONE; o_d = s_q; end
      default: state_d = EMPTY;
    endcase
  end
  // state, payload registers, registered ready and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      o_q <= '0;
      s_q <= '0;
      ovf_q <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      o_q <= o_d;
      s_q <= s_d;
      ovf_q <= ovf_d;
      in_ready_q <= state_d != TWO;
    end
  end
  assign in_ready = in_ready_q;
  assign out_valid = state_q != EMPTY;
  assign out_words = o_q[P-2:0];
  assign out_last = o_q[P-1];
  assign ovf = ovf_q;
endmodule
